// File: rtl/hls_deadlock_pkg.sv
// Shared types and record layout for the HLS deadlock report unit.
// FSM encoding, index/record width helpers and record field offsets.
package hls_deadlock_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REPORT,
    ST_HOLD
  } state_t;

  localparam int REC_TS_LSB = 0;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rec_width(
    input int n,
    input int ts_w
  );
    return idx_width(n) + ts_w;
  endfunction

  function automatic int rec_idx_lsb(input int ts_w);
    return ts_w;
  endfunction

endpackage

// File: rtl/hls_deadlock_persist_counter.sv
// Per-monitor persistence counter for the deadlock report unit.
// Counts consecutive block cycles, saturating at THRESH.
module hls_deadlock_persist_counter #(
  parameter int THRESH = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic block,
  output logic confirmed
);

  localparam int CW = $clog2(THRESH + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || clear || !block) begin
      cnt <= '0;
    end else if (cnt != CW'(THRESH)) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign confirmed = (cnt == CW'(THRESH));

endmodule

// File: rtl/hls_deadlock_report_unit.sv
// Deadlock confirmation and report streaming for the HLS monitor chain.
// Captures offending monitors once, then streams one record per monitor.
module hls_deadlock_report_unit
  import hls_deadlock_pkg::*;
#(
  parameter int NUM_MON = 4,
  parameter int THRESH  = 16,
  parameter int TS_W    = 32,
  parameter int IDX_W   = idx_width(NUM_MON)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic [NUM_MON-1:0]      block_sigs,
  output logic                    deadlock,
  output logic [NUM_MON-1:0]      deadlock_mask,
  output logic                    rpt_valid,
  input  logic                    rpt_ready,
  output logic [IDX_W+TS_W-1:0]   rpt_data,
  output logic                    rpt_last
);

  localparam int REC_W   = rec_width(NUM_MON, TS_W);
  localparam int IDX_LSB = rec_idx_lsb(TS_W);

  logic [TS_W-1:0]    ts;
  logic [TS_W-1:0]    ts_cap;
  logic [NUM_MON-1:0] confirmed;
  logic [NUM_MON-1:0] mask;
  logic [NUM_MON-1:0] pending;
  logic [NUM_MON-1:0] low_bit;
  logic [NUM_MON-1:0] rest;
  logic [IDX_W-1:0]   low_idx;
  logic               handshake;
  logic               capture;
  state_t             state;
  state_t             state_nx;

  always_ff @(posedge clock) begin
    if (reset) begin
      ts <= '0;
    end else begin
      ts <= ts + TS_W'(1);
    end
  end

  for (genvar i = 0; i < NUM_MON; i++) begin : g_mon
    hls_deadlock_persist_counter #(
      .THRESH(THRESH)
    ) u_cnt (
      .clock    (clock),
      .reset    (reset),
      .clear    (clear),
      .block    (block_sigs[i]),
      .confirmed(confirmed[i])
    );
  end

  // Lowest un-reported monitor goes out first.
  always_comb begin
    low_idx = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (pending[i]) begin
        low_idx = IDX_W'(i);
      end
    end
  end

  assign low_bit = pending & (~pending + NUM_MON'(1));
  assign rest    = pending & ~low_bit;

  assign rpt_valid = (state == ST_REPORT);
  assign rpt_last  = ~|rest;
  assign handshake = rpt_valid & rpt_ready;
  assign capture   = (state == ST_IDLE) && (|confirmed);

  assign rpt_data[REC_W-1:IDX_LSB]      = low_idx;
  assign rpt_data[IDX_LSB-1:REC_TS_LSB] = ts_cap;

  assign deadlock_mask = mask;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: begin
        if (|confirmed) state_nx = ST_REPORT;
      end
      ST_REPORT: begin
        if (handshake && rpt_last) state_nx = ST_HOLD;
      end
      ST_HOLD: begin
        state_nx = ST_HOLD;
      end
      default: state_nx = ST_IDLE;
    endcase
    if (clear) state_nx = ST_IDLE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      deadlock <= 1'b0;
      mask     <= '0;
      pending  <= '0;
      ts_cap   <= '0;
    end else if (clear) begin
      deadlock <= 1'b0;
      mask     <= '0;
      pending  <= '0;
    end else if (capture) begin
      deadlock <= 1'b1;
      mask     <= confirmed;
      pending  <= confirmed;
      ts_cap   <= ts;
    end else if (handshake) begin
      pending  <= rest;
    end
  end

endmodule

// File: tb/tb_hls_deadlock_report_unit.sv
// Randomized and directed bench for hls_deadlock_report_unit.
// A 32-bit and a 4-bit timestamp instance share all stimulus.
module tb_hls_deadlock_report_unit;

  localparam int NM = 4;
  localparam int TH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [3:0]  block_sigs = '0;
  logic        rpt_ready = 1'b0;

  logic        deadlock;
  logic [3:0]  deadlock_mask;
  logic        rpt_valid;
  logic [33:0] rpt_data;
  logic        rpt_last;

  logic        deadlock_w;
  logic [3:0]  deadlock_mask_w;
  logic        rpt_valid_w;
  logic [5:0]  rpt_data_w;
  logic        rpt_last_w;

  int vectors = 0;
  int miscompares = 0;

  logic        m_dl;
  logic [3:0]  m_mask;
  logic [31:0] m_ts;
  logic [31:0] m_tscap;
  int          m_q[$];
  int          m_run[NM];

  always #5 clock = ~clock;

  hls_deadlock_report_unit #(
    .NUM_MON(NM), .THRESH(TH), .TS_W(32)
  ) u_dut (
    .clock        (clock),
    .reset        (reset),
    .clear        (clear),
    .block_sigs   (block_sigs),
    .deadlock     (deadlock),
    .deadlock_mask(deadlock_mask),
    .rpt_valid    (rpt_valid),
    .rpt_ready    (rpt_ready),
    .rpt_data     (rpt_data),
    .rpt_last     (rpt_last)
  );

  hls_deadlock_report_unit #(
    .NUM_MON(NM), .THRESH(TH), .TS_W(4)
  ) u_dut_w (
    .clock        (clock),
    .reset        (reset),
    .clear        (clear),
    .block_sigs   (block_sigs),
    .deadlock     (deadlock_w),
    .deadlock_mask(deadlock_mask_w),
    .rpt_valid    (rpt_valid_w),
    .rpt_ready    (rpt_ready),
    .rpt_data     (rpt_data_w),
    .rpt_last     (rpt_last_w)
  );

  // Model: run lengths, a sticky flag and a queue of indices to report.
  task automatic model_step();
    logic [3:0] c;
    if (reset) begin
      m_ts = '0;
      m_dl = 1'b0;
      m_mask = '0;
      m_tscap = '0;
      m_q.delete();
      for (int i = 0; i < NM; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < NM; i++) c[i] = (m_run[i] >= TH);
      if (clear) begin
        m_dl = 1'b0;
        m_mask = '0;
        m_q.delete();
        for (int i = 0; i < NM; i++) m_run[i] = 0;
      end else begin
        if (m_q.size() != 0 && rpt_ready) void'(m_q.pop_front());
        if (!m_dl && c != 0) begin
          m_dl = 1'b1;
          m_mask = c;
          m_tscap = m_ts;
          for (int i = 0; i < NM; i++) if (c[i]) m_q.push_back(i);
        end
        for (int i = 0; i < NM; i++)
          m_run[i] = block_sigs[i] ? m_run[i] + 1 : 0;
      end
      m_ts = m_ts + 32'd1;
    end
  endtask

  task automatic drive(
    input logic       rst,
    input logic       clr,
    input logic [3:0] blk,
    input logic       rdy
  );
    reset = rst;
    clear = clr;
    block_sigs = blk;
    rpt_ready = rdy;
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  function automatic logic [53:0] act_vec();
    logic [34:0] r1;
    logic [6:0]  r2;
    r1 = rpt_valid ? {rpt_last, rpt_data} : 35'd0;
    r2 = rpt_valid_w ? {rpt_last_w, rpt_data_w} : 7'd0;
    return {deadlock, deadlock_mask, rpt_valid, r1,
            deadlock_w, deadlock_mask_w, rpt_valid_w, r2};
  endfunction

  function automatic logic [53:0] exp_vec();
    logic        v;
    logic [1:0]  idx;
    logic        lst;
    logic [34:0] r1;
    logic [6:0]  r2;
    v = (m_q.size() != 0);
    idx = v ? 2'(m_q[0]) : 2'd0;
    lst = (m_q.size() == 1);
    r1 = v ? {lst, idx, m_tscap} : 35'd0;
    r2 = v ? {lst, idx, m_tscap[3:0]} : 7'd0;
    return {m_dl, m_mask, v, r1, m_dl, m_mask, v, r2};
  endfunction

  task automatic test_reset();
    drive(1'b1, 1'b0, 4'hF, 1'b1);
    drive(1'b1, 1'b0, 4'hF, 1'b1);
    vectors++;
    if ({deadlock, deadlock_mask, rpt_valid} !== 6'd0 ||
        {deadlock_w, deadlock_mask_w, rpt_valid_w} !== 6'd0) begin
      miscompares++;
      $display("FAIL reset: got %b/%b/%b expected 0",
               deadlock, deadlock_mask, rpt_valid);
    end
  endtask

  task automatic test_no_confirm();
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 4; k++) begin
        drive(1'b0, 1'b0, (k < 3) ? 4'b0100 : 4'b0000, 1'b1);
        vectors++;
        if (deadlock !== 1'b0 || rpt_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL no_confirm: dl=%b valid=%b expected 0/0",
                   deadlock, rpt_valid);
        end
      end
    end
  endtask

  task automatic test_single();
    drive(1'b1, 1'b0, 4'b0000, 1'b1);
    while (m_ts < 32'd10) drive(1'b0, 1'b0, 4'b0000, 1'b1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 4'b0010, 1'b1);
      vectors++;
      if (deadlock !== 1'b0) begin
        miscompares++;
        $display("FAIL single_early: dl=%b expected 0", deadlock);
      end
    end
    drive(1'b0, 1'b0, 4'b0010, 1'b1);
    vectors++;
    if ({deadlock, deadlock_mask, rpt_valid, rpt_last} !== 7'b1001011 ||
        rpt_data !== {2'd1, 32'd14} || rpt_data_w !== {2'd1, 4'd14}) begin
      miscompares++;
      $display("FAIL single_rec: got dl=%b m=%b v=%b l=%b d=%h expected 1/0010/1/1/%h",
               deadlock, deadlock_mask, rpt_valid, rpt_last, rpt_data,
               {2'd1, 32'd14});
    end
    drive(1'b0, 1'b0, 4'b0010, 1'b1);
    drive(1'b0, 1'b0, 4'b0010, 1'b1);
    vectors++;
    if (rpt_valid !== 1'b0 || deadlock !== 1'b1 ||
        deadlock_mask !== 4'b0010) begin
      miscompares++;
      $display("FAIL single_hold: v=%b dl=%b m=%b expected 0/1/0010",
               rpt_valid, deadlock, deadlock_mask);
    end
    drive(1'b0, 1'b1, 4'b0000, 1'b1);
  endtask

  task automatic test_stall();
    logic [33:0] d0;
    for (int k = 0; k < 10 && !deadlock; k++)
      drive(1'b0, 1'b0, 4'b1001, 1'b0);
    d0 = rpt_data;
    for (int k = 0; k < 3; k++) begin
      vectors++;
      if (rpt_valid !== 1'b1 || rpt_last !== 1'b0 ||
          rpt_data !== d0 || rpt_data !== {2'd0, m_tscap} ||
          deadlock_mask !== 4'b1001) begin
        miscompares++;
        $display("FAIL stall_rec0: v=%b l=%b d=%h m=%b expected 1/0/%h/1001",
                 rpt_valid, rpt_last, rpt_data, deadlock_mask,
                 {2'd0, m_tscap});
      end
      drive(1'b0, 1'b0, 4'b1001, 1'b0);
    end
    drive(1'b0, 1'b0, 4'b1001, 1'b1);
    vectors++;
    if (rpt_valid !== 1'b1 || rpt_last !== 1'b1 ||
        rpt_data !== {2'd3, d0[31:0]}) begin
      miscompares++;
      $display("FAIL stall_rec1: v=%b l=%b d=%h expected 1/1/%h",
               rpt_valid, rpt_last, rpt_data, {2'd3, d0[31:0]});
    end
    drive(1'b0, 1'b0, 4'b1001, 1'b1);
    vectors++;
    if (rpt_valid !== 1'b0 || deadlock !== 1'b1) begin
      miscompares++;
      $display("FAIL stall_done: v=%b dl=%b expected 0/1",
               rpt_valid, deadlock);
    end
    drive(1'b0, 1'b1, 4'b0000, 1'b0);
  endtask

  task automatic test_clear();
    for (int k = 0; k < 10 && !deadlock; k++)
      drive(1'b0, 1'b0, 4'b0101, 1'b0);
    drive(1'b0, 1'b1, 4'b0100, 1'b1);
    vectors++;
    if ({deadlock, deadlock_mask, rpt_valid} !== 6'd0) begin
      miscompares++;
      $display("FAIL clear: got %b/%b/%b expected 0/0000/0",
               deadlock, deadlock_mask, rpt_valid);
    end
    for (int k = 0; k < 4; k++) drive(1'b0, 1'b0, 4'b0100, 1'b0);
    vectors++;
    if (deadlock !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_early: dl=%b expected 0", deadlock);
    end
    drive(1'b0, 1'b0, 4'b0100, 1'b0);
    vectors++;
    if (deadlock !== 1'b1 || deadlock_mask !== 4'b0100 ||
        rpt_data[33:32] !== 2'd2 || rpt_last !== 1'b1) begin
      miscompares++;
      $display("FAIL clear_retrig: dl=%b m=%b d=%h expected 1/0100/idx 2",
               deadlock, deadlock_mask, rpt_data);
    end
    drive(1'b0, 1'b1, 4'b0000, 1'b0);
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 10 && !deadlock; k++)
      drive(1'b0, 1'b0, 4'b1000, 1'b0);
    drive(1'b1, 1'b0, 4'b1000, 1'b1);
    vectors++;
    if ({deadlock, deadlock_mask, rpt_valid} !== 6'd0 ||
        {deadlock_w, deadlock_mask_w, rpt_valid_w} !== 6'd0) begin
      miscompares++;
      $display("FAIL reset_mid: got %b/%b/%b expected 0",
               deadlock, deadlock_mask, rpt_valid);
    end
    drive(1'b0, 1'b0, 4'b0000, 1'b0);
  endtask

  task automatic test_wrap();
    for (int k = 0; k < 20 && m_ts[3:0] != 4'd11; k++)
      drive(1'b0, 1'b0, 4'b0000, 1'b0);
    for (int k = 0; k < 5; k++) drive(1'b0, 1'b0, 4'b0001, 1'b0);
    vectors++;
    if (rpt_valid_w !== 1'b1 || rpt_data_w !== {2'd0, 4'd15} ||
        rpt_data[3:0] !== 4'd15) begin
      miscompares++;
      $display("FAIL wrap: v=%b d=%h expected 1/%h",
               rpt_valid_w, rpt_data_w, {2'd0, 4'd15});
    end
    drive(1'b0, 1'b0, 4'b0001, 1'b1);
    drive(1'b0, 1'b1, 4'b0000, 1'b0);
    for (int k = 0; k < 10 && !deadlock; k++)
      drive(1'b0, 1'b0, 4'b0010, 1'b0);
    vectors++;
    if (act_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL wrap_later: got %h expected %h",
               act_vec(), exp_vec());
    end
    drive(1'b0, 1'b1, 4'b0000, 1'b0);
  endtask

  task automatic test_random();
    logic [3:0] blk;
    logic       rst;
    logic       clr;
    blk = '0;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NM; i++)
        if ($urandom_range(7) == 0) blk[i] = ~blk[i];
      rst = ($urandom_range(199) == 0);
      clr = ($urandom_range(63) == 0);
      drive(rst, clr, blk, 1'($urandom_range(1)));
      vectors++;
      if (act_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random[%0d]: got %h expected %h",
                 n, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    @(negedge clock);
    test_reset();
    test_no_confirm();
    test_single();
    test_stall();
    test_clear();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
